// File: rtl/gc_response_tx_pkg.sv
// Shared definitions for the GameCube one-wire link: bit-cell timing, frame lengths,
// FSM encodings and small helpers used by the transmitter and the command receiver.
package gc_response_tx_pkg;

  localparam int GC_CLKS_PER_US = 40;

  localparam int GC_CELL_US     = 4;
  localparam int GC_LOW_ONE_US  = 1;
  localparam int GC_LOW_ZERO_US = 3;
  localparam int GC_STOP_LOW_US = 1;
  localparam int GC_STOP_US     = 2;

  localparam int GC_LEN_ID     = 24;
  localparam int GC_LEN_POLL   = 64;
  localparam int GC_LEN_ORIGIN = 80;
  localparam int GC_MAX_BITS   = GC_LEN_ORIGIN;

  typedef enum logic [1:0] {
    GC_ST_IDLE = 2'd0,
    GC_ST_BIT  = 2'd1,
    GC_ST_STOP = 2'd2
  } gc_state_e;

  // Oversized requests are sent as the longest frame the shifter can hold.
  function automatic logic [6:0] gc_clamp_len(input logic [6:0] len,
                                              input logic [6:0] max_len);
    return (len > max_len) ? max_len : len;
  endfunction

endpackage

// File: rtl/gc_response_tx_cell_timer.sv
// Bit-cell counter for the one-wire link: counts 0..4C-1 and decodes the
// 1 us / 3 us low-phase boundaries plus the stop-bit and cell terminal counts.
module gc_response_tx_cell_timer
  import gc_response_tx_pkg::*;
#(
  parameter int CLKS_PER_US = GC_CLKS_PER_US
) (
  input  logic CLK,
  input  logic RESET,
  input  logic clear,
  input  logic run,
  output logic lt_one,
  output logic lt_zero,
  output logic lt_stop_low,
  output logic stop_last,
  output logic cell_last
);

  localparam int CNT_W = $clog2(GC_CELL_US * CLKS_PER_US);

  localparam logic [CNT_W-1:0] ONE_END      = CNT_W'(GC_LOW_ONE_US * CLKS_PER_US);
  localparam logic [CNT_W-1:0] ZERO_END     = CNT_W'(GC_LOW_ZERO_US * CLKS_PER_US);
  localparam logic [CNT_W-1:0] STOP_LOW_END = CNT_W'(GC_STOP_LOW_US * CLKS_PER_US);
  localparam logic [CNT_W-1:0] STOP_LAST    = CNT_W'(GC_STOP_US * CLKS_PER_US - 1);
  localparam logic [CNT_W-1:0] CELL_LAST    = CNT_W'(GC_CELL_US * CLKS_PER_US - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= (cnt == CELL_LAST) ? '0 : cnt + CNT_W'(1);
    end
  end

  assign lt_one      = (cnt < ONE_END);
  assign lt_zero     = (cnt < ZERO_END);
  assign lt_stop_low = (cnt < STOP_LOW_END);
  assign stop_last   = (cnt == STOP_LAST);
  assign cell_last   = (cnt == CELL_LAST);

endmodule

// File: rtl/gc_response_tx.sv
// GameCube one-wire response transmitter: shifts a latched response word MSB first
// as 4 us bit cells followed by a stop bit, driving the open-drain pad enable.
module gc_response_tx
  import gc_response_tx_pkg::*;
#(
  parameter int CLKS_PER_US = GC_CLKS_PER_US,
  parameter int MAX_BITS    = GC_MAX_BITS
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                START,
  input  logic [6:0]          LEN,
  input  logic [MAX_BITS-1:0] DATA,
  output logic                BUSY,
  output logic                DONE,
  output logic                LINE_LOW
);

  localparam logic [6:0] MAX_LEN = 7'(MAX_BITS);

  gc_state_e           state;
  logic [MAX_BITS-1:0] shreg;
  logic [6:0]          bit_cnt;
  logic                fin;

  logic       accept;
  logic [6:0] len_c;
  logic       line_low_nx;
  logic       lt_one, lt_zero, lt_stop_low, stop_last, cell_last;

  // BUSY gates acceptance as well as the state: the cycle right after DONE is
  // IDLE with BUSY still high from the previous frame's last cycle.
  assign accept = START && !BUSY && (state == GC_ST_IDLE);
  assign len_c  = gc_clamp_len(LEN, MAX_LEN);

  gc_response_tx_cell_timer #(
    .CLKS_PER_US(CLKS_PER_US)
  ) u_cell_timer (
    .CLK        (CLK),
    .RESET      (RESET),
    .clear      (accept || ((state == GC_ST_STOP) && stop_last)),
    .run        (state != GC_ST_IDLE),
    .lt_one     (lt_one),
    .lt_zero    (lt_zero),
    .lt_stop_low(lt_stop_low),
    .stop_last  (stop_last),
    .cell_last  (cell_last)
  );

  always_comb begin
    line_low_nx = 1'b0;
    case (state)
      GC_ST_BIT:  line_low_nx = shreg[MAX_BITS-1] ? lt_one : lt_zero;
      GC_ST_STOP: line_low_nx = lt_stop_low;
      default:    line_low_nx = 1'b0;
    endcase
  end

  // Outputs are the registered decode of the current state, so every pin
  // trails the FSM by one cycle; fin delays DONE to line up with BUSY falling.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state    <= GC_ST_IDLE;
      shreg    <= '0;
      bit_cnt  <= '0;
      fin      <= 1'b0;
      LINE_LOW <= 1'b0;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
    end else begin
      LINE_LOW <= line_low_nx;
      BUSY     <= (state != GC_ST_IDLE);
      DONE     <= fin;
      fin      <= 1'b0;
      case (state)
        GC_ST_IDLE: begin
          if (accept) begin
            shreg   <= DATA;
            bit_cnt <= len_c;
            state   <= (len_c == 7'd0) ? GC_ST_STOP : GC_ST_BIT;
          end
        end
        GC_ST_BIT: begin
          if (cell_last) begin
            shreg   <= shreg << 1;
            bit_cnt <= bit_cnt - 7'd1;
            if (bit_cnt == 7'd1) state <= GC_ST_STOP;
          end
        end
        GC_ST_STOP: begin
          if (stop_last) begin
            state <= GC_ST_IDLE;
            fin   <= 1'b1;
          end
        end
        default: state <= GC_ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gc_response_tx.sv
// Directed bench for gc_response_tx: one instance at 40 clocks/us for exact cell
// timing, one at 4 clocks/us for full-length frames, back-to-back and abort cases.
module tb_gc_response_tx;
  import gc_response_tx_pkg::*;

  int checks = 0;
  int errors = 0;

  logic CLK = 1'b0;
  logic RESET = 1'b0;

  logic        start40 = 1'b0, start4 = 1'b0;
  logic [6:0]  len40 = '0, len4 = '0;
  logic [79:0] data40 = '0, data4 = '0;
  logic        busy40, done40, ll40;
  logic        busy4, done4, ll4;

  always #5 CLK = ~CLK;

  gc_response_tx #(.CLKS_PER_US(40), .MAX_BITS(80)) u_tx40 (
    .CLK(CLK), .RESET(RESET), .START(start40), .LEN(len40), .DATA(data40),
    .BUSY(busy40), .DONE(done40), .LINE_LOW(ll40)
  );

  gc_response_tx #(.CLKS_PER_US(4), .MAX_BITS(80)) u_tx4 (
    .CLK(CLK), .RESET(RESET), .START(start4), .LEN(len4), .DATA(data4),
    .BUSY(busy4), .DONE(done4), .LINE_LOW(ll4)
  );

  int runs[$];
  int busy_w, done_at, done_seen;

  task automatic launch40(input logic [6:0] len, input logic [79:0] data);
    @(negedge CLK);
    start40 = 1'b1; len40 = len; data40 = data;
    @(posedge CLK); #1;
    start40 = 1'b0; len40 = '0; data40 = '0;
  endtask

  task automatic launch4(input logic [6:0] len, input logic [79:0] data);
    @(negedge CLK);
    start4 = 1'b1; len4 = len; data4 = data;
    @(posedge CLK); #1;
    start4 = 1'b0; len4 = 7'd3; data4 = '0;
  endtask

  // Samples u_tx4 once per cycle from the accept edge, collecting low-pulse widths,
  // BUSY width and the cycle DONE appears; returns while still in the DONE cycle.
  task automatic measure4(input int budget, input bit inject);
    int width;
    width = 0;
    runs.delete();
    busy_w = 0; done_at = -1; done_seen = 0;
    for (int n = 0; n < budget; n++) begin
      @(negedge CLK);
      if (inject && (n == 49 || n == 199)) begin
        start4 = 1'b1; len4 = 7'd5; data4 = '0;
      end else begin
        start4 = 1'b0;
      end
      if (busy4 === 1'b1) busy_w++;
      if (ll4 === 1'b1) width++;
      else if (width > 0) begin
        runs.push_back(width);
        width = 0;
      end
      if (done4 === 1'b1) begin
        done_at = n; done_seen = 1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int bad40, bad4;
    bad40 = 0; bad4 = 0;
    RESET = 1'b0;
    start40 = 1'b1; len40 = 7'd1; data40 = '1;
    start4  = 1'b1; len4  = 7'd24; data4 = '1;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      if ({ll40, busy40, done40} !== 3'b000) bad40++;
      if ({ll4, busy4, done4} !== 3'b000) bad4++;
    end
    checks++;
    if (bad40 != 0) begin
      errors++; $display("FAIL reset_hold_c40: %0d cycles with outputs active, want 0", bad40);
    end
    checks++;
    if (bad4 != 0) begin
      errors++; $display("FAIL reset_hold_c4: %0d cycles with outputs active, want 0", bad4);
    end
    start40 = 1'b0; start4 = 1'b0;
    RESET = 1'b1;
    bad40 = 0; bad4 = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      if ({ll40, busy40, done40} !== 3'b000) bad40++;
      if ({ll4, busy4, done4} !== 3'b000) bad4++;
    end
    checks++;
    if (bad40 + bad4 != 0) begin
      errors++; $display("FAIL reset_release_idle: %0d cycles active after release, want 0", bad40 + bad4);
    end
  endtask

  task automatic test_bit40(input logic b);
    int bad_ll, bad_busy, bad_done, first_ll, first_busy, first_done, low_end;
    logic exp_ll, exp_busy, exp_done;
    bad_ll = 0; bad_busy = 0; bad_done = 0;
    first_ll = -1; first_busy = -1; first_done = -1;
    low_end = b ? 40 : 120;
    launch40(7'd1, {b, {79{~b}}});
    for (int n = 0; n < 260; n++) begin
      @(negedge CLK);
      exp_ll   = (n >= 1 && n <= low_end) || (n >= 161 && n <= 200);
      exp_busy = (n >= 1 && n <= 240);
      exp_done = (n == 241);
      if (ll40 !== exp_ll) begin
        if (bad_ll == 0) first_ll = n;
        bad_ll++;
      end
      if (busy40 !== exp_busy) begin
        if (bad_busy == 0) first_busy = n;
        bad_busy++;
      end
      if (done40 !== exp_done) begin
        if (bad_done == 0) first_done = n;
        bad_done++;
      end
    end
    checks++;
    if (bad_ll != 0) begin
      errors++; $display("FAIL c40_bit%0b_line_low: %0d cycles wrong, want 0 (first at cycle %0d)", b, bad_ll, first_ll);
    end
    checks++;
    if (bad_busy != 0) begin
      errors++; $display("FAIL c40_bit%0b_busy: %0d cycles wrong, want 0 (first at cycle %0d)", b, bad_busy, first_busy);
    end
    checks++;
    if (bad_done != 0) begin
      errors++; $display("FAIL c40_bit%0b_done: %0d cycles wrong, want 0 (first at cycle %0d)", b, bad_done, first_done);
    end
  endtask

  task automatic test_id_frame();
    logic [23:0] pat;
    int bad_w, extra;
    pat = 24'h090000;
    launch4(7'(GC_LEN_ID), {pat, 56'hFF_FFFF_FFFF_FFFF});
    measure4(600, 1'b0);
    checks++;
    if (done_at != 393) begin
      errors++; $display("FAIL id_done_cycle: got %0d, want 393", done_at);
    end
    checks++;
    if (busy_w != 392) begin
      errors++; $display("FAIL id_busy_width: got %0d, want 392", busy_w);
    end
    checks++;
    if (runs.size() != 25) begin
      errors++; $display("FAIL id_low_pulse_count: got %0d, want 25", runs.size());
    end
    bad_w = 0;
    for (int i = 0; i < runs.size() && i < 25; i++) begin
      if (runs[i] != ((i == 24) ? 4 : (pat[23-i] ? 4 : 12))) bad_w++;
    end
    checks++;
    if (bad_w != 0) begin
      errors++; $display("FAIL id_low_widths: %0d pulses wrong, want 0", bad_w);
    end
    extra = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (done4 !== 1'b0 || busy4 !== 1'b0) extra++;
    end
    checks++;
    if (extra != 0) begin
      errors++; $display("FAIL id_after_done: %0d cycles with DONE/BUSY set, want 0", extra);
    end
  endtask

  task automatic test_ignore_and_back_to_back();
    logic [63:0] pat;
    int bad_w, bad;
    logic exp_ll, exp_busy, exp_done;
    pat = 64'hA5C3_0F00_FF12_3456;
    launch4(7'(GC_LEN_POLL), {pat, 16'h0000});
    measure4(1200, 1'b1);
    checks++;
    if (busy_w != 1032) begin
      errors++; $display("FAIL poll_busy_width: got %0d, want 1032", busy_w);
    end
    checks++;
    if (done_at != 1033) begin
      errors++; $display("FAIL poll_done_cycle: got %0d, want 1033", done_at);
    end
    checks++;
    if (runs.size() != 65) begin
      errors++; $display("FAIL poll_low_pulse_count: got %0d, want 65", runs.size());
    end
    bad_w = 0;
    for (int i = 0; i < runs.size() && i < 65; i++) begin
      if (runs[i] != ((i == 64) ? 4 : (pat[63-i] ? 4 : 12))) bad_w++;
    end
    checks++;
    if (bad_w != 0) begin
      errors++; $display("FAIL poll_low_widths: %0d pulses wrong, want 0", bad_w);
    end
    // Still in the DONE cycle: request a stop-bit-only frame right away.
    if (done_seen != 0) begin
      start4 = 1'b1; len4 = 7'd0; data4 = '1;
      @(posedge CLK); #1;
      start4 = 1'b0;
    end
    bad = 0;
    for (int r = 0; r < 12; r++) begin
      @(negedge CLK);
      exp_ll   = (r >= 1 && r <= 4);
      exp_busy = (r >= 1 && r <= 8);
      exp_done = (r == 9);
      if (ll4 !== exp_ll || busy4 !== exp_busy || done4 !== exp_done) begin
        if (bad == 0)
          $display("FAIL b2b_stop_only_cycle%0d: got ll/busy/done %b%b%b, want %b%b%b",
                   r, ll4, busy4, done4, exp_ll, exp_busy, exp_done);
        bad++;
      end
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL b2b_stop_only: %0d cycles wrong, want 0", bad);
    end
  endtask

  task automatic test_reset_mid_frame();
    int busy_before, stray;
    busy_before = 0;
    launch4(7'(GC_LEN_POLL), {64'hFFFF_0000_FFFF_0000, 16'h0});
    for (int n = 0; n < 100; n++) begin
      @(negedge CLK);
      if (n == 99) begin
        busy_before = (busy4 === 1'b1) ? 1 : 0;
        RESET = 1'b0;
      end
    end
    checks++;
    if (busy_before != 1) begin
      errors++; $display("FAIL abort_busy_before: got %0d, want 1", busy_before);
    end
    @(negedge CLK);
    checks++;
    if (ll4 !== 1'b0 || busy4 !== 1'b0 || done4 !== 1'b0) begin
      errors++; $display("FAIL abort_outputs: got ll/busy/done %b%b%b, want 000", ll4, busy4, done4);
    end
    RESET = 1'b1;
    stray = 0;
    for (int n = 0; n < 1100; n++) begin
      @(negedge CLK);
      if (done4 !== 1'b0 || busy4 !== 1'b0 || ll4 !== 1'b0) stray++;
    end
    checks++;
    if (stray != 0) begin
      errors++; $display("FAIL abort_no_resume: %0d active cycles after abort, want 0", stray);
    end
  endtask

  task automatic test_len_clamp();
    int bad_w;
    launch4(7'd100, '1);
    measure4(1500, 1'b0);
    checks++;
    if (busy_w != 1288) begin
      errors++; $display("FAIL clamp_busy_width: got %0d, want 1288", busy_w);
    end
    checks++;
    if (runs.size() != 81) begin
      errors++; $display("FAIL clamp_low_pulse_count: got %0d, want 81", runs.size());
    end
    bad_w = 0;
    for (int i = 0; i < runs.size(); i++) if (runs[i] != 4) bad_w++;
    checks++;
    if (bad_w != 0 || done_seen != 1) begin
      errors++; $display("FAIL clamp_widths_done: %0d bad pulses, done %0d, want 0 and 1", bad_w, done_seen);
    end
  endtask

  initial begin
    test_reset();
    test_bit40(1'b1);
    test_bit40(1'b0);
    test_id_frame();
    test_ignore_and_back_to_back();
    test_reset_mid_frame();
    test_len_clamp();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
